neuron_mac_sequencer: RTL and testbench

- Sequences one neuron dot product through the shared combinational sign-magnitude multiplier. The multiplier takes 16-bit operands (bit15 sign, 14:0 magnitude) and returns a 31-bit product (bit30 sign, 29:0 magnitude).
- Fetches input/weight pairs from two 1-cycle-latency RAMs, drives the multiplier operands and accumulates the products in two's complement with saturation.
- Start/busy/done handshake to the layer controller; one instance per multiplier.

---
 rtl/neuron_mac_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer
//   Sequences one neuron dot product through a shared combinational
//   sign-magnitude multiplier. Input/weight pairs are fetched from two
//   1-cycle-latency RAMs, registered onto the multiplier operands, and the
//   returned products are accumulated in saturating two's complement.
//
// Ports:
//   iClk, iRst          clock (rising edge) and asynchronous active-high reset
//   iStart              start request, only honoured while idle
//   iLen                number of pairs N, captured with iStart
//   iBaseX, iBaseW      vector base addresses, captured with iStart
//   oRdEn               read strobe shared by both RAMs
//   oAddrX, oAddrW      RAM addresses (wrap modulo 2^ADDR_W)
//   iDataX, iDataW      RAM read data, valid the cycle after oRdEn
//   oMulA, oMulB        registered multiplier operands (sign-magnitude)
//   iMulP               multiplier product (bit30 sign, 29:0 magnitude)
//   oBusy               high from the first fetch cycle through the done cycle
//   oDone               single-cycle completion pulse
//   oResult             signed accumulator value
//   oSat                sticky saturation flag for the current run

module neuron_mac_sequencer #(
  parameter int LEN_W  = 10,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 40
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [LEN_W-1:0]  iLen,
  input  logic [ADDR_W-1:0] iBaseX,
  input  logic [ADDR_W-1:0] iBaseW,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oAddrX,
  output logic [ADDR_W-1:0] oAddrW,
  input  logic [15:0]       iDataX,
  input  logic [15:0]       iDataW,
  output logic [15:0]       oMulA,
  output logic [15:0]       oMulB,
  input  logic [30:0]       iMulP,
  output logic              oBusy,
  output logic              oDone,
  output logic [ACC_W-1:0]  oResult,
  output logic              oSat
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_x_q, base_x_d;
  logic [ADDR_W-1:0] base_w_q, base_w_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mul_valid_q, mul_valid_d;
  logic [15:0]       mul_a_q, mul_a_d;
  logic [15:0]       mul_b_q, mul_b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;

  logic              start_accept;
  logic              last_issue;
  logic              rd_en;
  logic [ACC_W-1:0]  prod_mag;
  logic [ACC_W-1:0]  prod_val;
  logic [ACC_W:0]    sum_ext;
  logic              sum_ovf;
  logic [ACC_W-1:0]  acc_next;

  assign start_accept = (state_q == ST_IDLE) && iStart;
  assign last_issue   = (state_q == ST_FETCH) && (idx_q == len_q - LEN_W'(1));

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DRAIN only waits for the read stage to empty: the
  // operand stage, if still valid, retires on the same edge that enters DONE,
  // so the done cycle already shows the final sum.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d = (iLen != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (last_issue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!rd_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state. Addresses are forced to zero outside FETCH
  // so that an asynchronous reset drives every output to zero at once.
  always_comb begin
    rd_en  = (state_q == ST_FETCH);
    oRdEn  = rd_en;
    oAddrX = '0;
    oAddrW = '0;
    if (rd_en) begin
      oAddrX = base_x_q + ADDR_W'(idx_q);
      oAddrW = base_w_q + ADDR_W'(idx_q);
    end
    oBusy  = (state_q != ST_IDLE);
    oDone  = (state_q == ST_DONE);
  end

  // Sign-magnitude product to two's complement, then saturating add. One
  // extra sum bit exposes overflow: when the top two bits differ the true
  // result is out of range, and the top bit tells which bound to clamp to.
  // A negative zero negates to zero, so it adds nothing.
  always_comb begin
    prod_mag = ACC_W'(iMulP[29:0]);
    prod_val = iMulP[30] ? (~prod_mag + ACC_W'(1)) : prod_mag;
    sum_ext  = {acc_q[ACC_W-1], acc_q} + {prod_val[ACC_W-1], prod_val};
    sum_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    if (sum_ovf) begin
      acc_next = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_ext[ACC_W-1:0];
    end
  end

  // Datapath next values: run parameters captured at start, the fetch index,
  // the two pipeline valid bits, operand registers that hold when idle, and
  // the accumulator. A start can only be accepted with the pipeline empty,
  // so the start clear never collides with an accumulate.
  always_comb begin
    len_d       = len_q;
    base_x_d    = base_x_q;
    base_w_d    = base_w_q;
    idx_d       = idx_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    rd_valid_d  = rd_en;
    mul_valid_d = rd_valid_q;

    if (rd_en) begin
      idx_d = idx_q + LEN_W'(1);
    end

    if (rd_valid_q) begin
      mul_a_d = iDataX;
      mul_b_d = iDataW;
    end

    if (mul_valid_q) begin
      acc_d = acc_next;
      sat_d = sat_q | sum_ovf;
    end

    if (start_accept) begin
      len_d    = iLen;
      base_x_d = iBaseX;
      base_w_d = iBaseW;
      idx_d    = '0;
      acc_d    = '0;
      sat_d    = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      len_q       <= '0;
      base_x_q    <= '0;
      base_w_q    <= '0;
      idx_q       <= '0;
      rd_valid_q  <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      len_q       <= len_d;
      base_x_q    <= base_x_d;
      base_w_q    <= base_w_d;
      idx_q       <= idx_d;
      rd_valid_q  <= rd_valid_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign oMulA   = mul_a_q;
  assign oMulB   = mul_b_q;
  assign oResult = acc_q;
  assign oSat    = sat_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer
//   Drives neuron_mac_sequencer with directed and random dot-product jobs
//   against two 1-cycle-latency RAM models and an ideal sign-magnitude
//   multiplier. Expected sums come from a plain integer dot product with
//   clamping; expected timing comes from the start-to-done cycle rules.

module tb_neuron_mac_sequencer;

  localparam int LEN_W  = 10;
  localparam int ADDR_W = 10;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              iClk;
  logic              iRst;
  logic              iStart;
  logic [LEN_W-1:0]  iLen;
  logic [ADDR_W-1:0] iBaseX;
  logic [ADDR_W-1:0] iBaseW;
  logic              oRdEn;
  logic [ADDR_W-1:0] oAddrX;
  logic [ADDR_W-1:0] oAddrW;
  logic [15:0]       iDataX;
  logic [15:0]       iDataW;
  logic [15:0]       oMulA;
  logic [15:0]       oMulB;
  logic [30:0]       iMulP;
  logic              oBusy;
  logic              oDone;
  logic [ACC_W-1:0]  oResult;
  logic              oSat;

  logic [15:0] memX [DEPTH];
  logic [15:0] memW [DEPTH];

  int total = 0;
  int bad   = 0;

  neuron_mac_sequencer #(
    .LEN_W (LEN_W),
    .ADDR_W(ADDR_W),
    .ACC_W (ACC_W)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iLen   (iLen),
    .iBaseX (iBaseX),
    .iBaseW (iBaseW),
    .oRdEn  (oRdEn),
    .oAddrX (oAddrX),
    .oAddrW (oAddrW),
    .iDataX (iDataX),
    .iDataW (iDataW),
    .oMulA  (oMulA),
    .oMulB  (oMulB),
    .iMulP  (iMulP),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oResult(oResult),
    .oSat   (oSat)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Two synchronous-read RAMs: data appears the cycle after the read strobe.
  always @(posedge iClk) begin
    if (oRdEn) begin
      iDataX <= memX[oAddrX];
      iDataW <= memW[oAddrW];
    end
  end

  // Ideal sign-magnitude multiplier.
  assign iMulP = {oMulA[15] ^ oMulB[15],
                  {15'd0, oMulA[14:0]} * {15'd0, oMulB[14:0]}};

  // Absolute time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference dot product: integer multiply-accumulate, clamped after every
  // step to the signed ACC_W range, with a sticky clamp flag.
  function automatic void refDot(input int len, input int bx, input int bw,
                                 output logic [ACC_W-1:0] res, output bit sat);
    longint acc;
    longint mag;
    longint p;
    longint maxV;
    longint minV;
    logic [15:0] x;
    logic [15:0] w;
    maxV = (longint'(1) <<< (ACC_W - 1)) - 1;
    minV = -(longint'(1) <<< (ACC_W - 1));
    acc  = 0;
    sat  = 1'b0;
    for (int k = 0; k < len; k++) begin
      x   = memX[(bx + k) % DEPTH];
      w   = memW[(bw + k) % DEPTH];
      mag = longint'(x[14:0]) * longint'(w[14:0]);
      p   = (x[15] ^ w[15]) ? -mag : mag;
      acc = acc + p;
      if (acc > maxV) begin
        acc = maxV;
        sat = 1'b1;
      end else if (acc < minV) begin
        acc = minV;
        sat = 1'b1;
      end
    end
    res = ACC_W'(acc);
  endfunction

  task automatic setPair(input int bx, input int bw, input int k, input logic [15:0] x, input logic [15:0] w);
    memX[(bx + k) % DEPTH] = x;
    memW[(bw + k) % DEPTH] = w;
  endtask

  task automatic fillRandom(input int bx, input int bw, input int len);
    for (int k = 0; k < len; k++) begin
      setPair(bx, bw, k, 16'($urandom), 16'($urandom));
    end
  endtask

  // Present a start request and return just after the accepting edge (E0).
  task automatic applyStimulus(input int len, input int bx, input int bw);
    @(negedge iClk);
    iStart = 1'b1;
    iLen   = LEN_W'(len);
    iBaseX = ADDR_W'(bx);
    iBaseW = ADDR_W'(bw);
    @(posedge iClk);
    #1 iStart = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdEn"},   64'(oRdEn),   64'd0);
    checkOutput({tag, "_addrX"},  64'(oAddrX),  64'd0);
    checkOutput({tag, "_addrW"},  64'(oAddrW),  64'd0);
    checkOutput({tag, "_mulA"},   64'(oMulA),   64'd0);
    checkOutput({tag, "_mulB"},   64'(oMulB),   64'd0);
    checkOutput({tag, "_busy"},   64'(oBusy),   64'd0);
    checkOutput({tag, "_done"},   64'(oDone),   64'd0);
    checkOutput({tag, "_result"}, 64'(oResult), 64'd0);
    checkOutput({tag, "_sat"},    64'(oSat),    64'd0);
  endtask

  // Follow a run from cycle 1, sampling on falling edges. Optional start
  // pulses (with junk parameters) are injected in cycles pulseA/pulseB.
  // With startAtDone set, a new request is raised in the done cycle and the
  // task returns straight away so the caller can check it is deferred.
  task automatic watchJob(input string tag, input int len, input int bx, input int bw,
                          input int pulseA, input int pulseB, input bit startAtDone,
                          input int nextLen, input int nextBx, input int nextBw);
    logic [ACC_W-1:0] expRes;
    bit expSat;
    int c;
    int doneCycle;
    int doneCount;
    int rdCount;
    int expDone;
    int budget;
    refDot(len, bx, bw, expRes, expSat);
    expDone   = (len == 0) ? 1 : len + 3;
    budget    = len + 8;
    c         = 0;
    doneCycle = 0;
    doneCount = 0;
    rdCount   = 0;
    while (c < budget && doneCount == 0) begin
      @(negedge iClk);
      c++;
      iStart = (c == pulseA) || (c == pulseB);
      if (iStart) begin
        iLen   = LEN_W'($urandom_range(1, 30));
        iBaseX = ADDR_W'($urandom);
        iBaseW = ADDR_W'($urandom);
      end
      checkOutput({tag, "_busy"}, 64'(oBusy), 64'd1);
      if (oRdEn) begin
        checkOutput({tag, "_addrX"}, 64'(oAddrX), 64'((bx + rdCount) % DEPTH));
        checkOutput({tag, "_addrW"}, 64'(oAddrW), 64'((bw + rdCount) % DEPTH));
        rdCount++;
      end
      if (oDone) begin
        doneCount++;
        doneCycle = c;
        checkOutput({tag, "_result"}, 64'(oResult), 64'(expRes));
        checkOutput({tag, "_sat"},    64'(oSat),    64'(expSat));
        if (startAtDone) begin
          iStart = 1'b1;
          iLen   = LEN_W'(nextLen);
          iBaseX = ADDR_W'(nextBx);
          iBaseW = ADDR_W'(nextBw);
        end
      end
    end
    checkOutput({tag, "_doneCycle"}, 64'(doneCycle), 64'(expDone));
    checkOutput({tag, "_rdCount"},   64'(rdCount),   64'(len));
    if (len > 0) begin
      checkOutput({tag, "_mulA"}, 64'(oMulA), 64'(memX[(bx + len - 1) % DEPTH]));
      checkOutput({tag, "_mulB"}, 64'(oMulB), 64'(memW[(bw + len - 1) % DEPTH]));
    end
    if (!startAtDone) begin
      iStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge iClk);
        checkOutput({tag, "_idleBusy"}, 64'(oBusy), 64'd0);
        checkOutput({tag, "_idleDone"}, 64'(oDone), 64'd0);
      end
      checkOutput({tag, "_holdResult"}, 64'(oResult), 64'(expRes));
      checkOutput({tag, "_holdSat"},    64'(oSat),    64'(expSat));
    end
  endtask

  // Directed sequence followed by random jobs.
  initial begin
    int len;
    int bx;
    int bw;

    iRst   = 1'b1;
    iStart = 1'b0;
    iLen   = '0;
    iBaseX = '0;
    iBaseW = '0;
    for (int a = 0; a < DEPTH; a++) begin
      memX[a] = 16'($urandom);
      memW[a] = 16'($urandom);
    end

    #1 checkAllZero("reset");
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    checkAllZero("afterReset");

    // Mixed-sign products with a zero weight.
    setPair(16, 512, 0, 16'h0003, 16'h0004);
    setPair(16, 512, 1, 16'h8002, 16'h0003);
    setPair(16, 512, 2, 16'h0005, 16'h8002);
    setPair(16, 512, 3, 16'h0001, 16'h0000);
    applyStimulus(4, 16, 512);
    watchJob("basic", 4, 16, 512, 0, 0, 1'b0, 0, 0, 0);

    // Zero length goes straight to done with no reads.
    applyStimulus(0, 100, 200);
    watchJob("zeroLen", 0, 100, 200, 0, 0, 1'b0, 0, 0, 0);

    // Negative-zero product contributes nothing.
    setPair(40, 60, 0, 16'h8003, 16'h0000);
    setPair(40, 60, 1, 16'h0002, 16'h0005);
    applyStimulus(2, 40, 60);
    watchJob("negZero", 2, 40, 60, 0, 0, 1'b0, 0, 0, 0);

    // Positive saturation, then a fresh run clears the flag.
    for (int k = 0; k < 4; k++) setPair(700, 720, k, 16'h7FFF, 16'h7FFF);
    applyStimulus(4, 700, 720);
    watchJob("satPos", 4, 700, 720, 0, 0, 1'b0, 0, 0, 0);
    setPair(730, 740, 0, 16'h0001, 16'h0001);
    applyStimulus(1, 730, 740);
    watchJob("afterSat", 1, 730, 740, 0, 0, 1'b0, 0, 0, 0);

    // Negative saturation.
    for (int k = 0; k < 4; k++) setPair(750, 760, k, 16'hFFFF, 16'h7FFF);
    applyStimulus(4, 750, 760);
    watchJob("satNeg", 4, 750, 760, 0, 0, 1'b0, 0, 0, 0);

    // Address wrap past the top of the RAM.
    fillRandom(1022, 5, 4);
    applyStimulus(4, 1022, 5);
    watchJob("wrap", 4, 1022, 5, 0, 0, 1'b0, 0, 0, 0);

    // Start requests mid-run are ignored.
    fillRandom(64, 128, 8);
    applyStimulus(8, 64, 128);
    watchJob("midStart", 8, 64, 128, 2, 5, 1'b0, 0, 0, 0);

    // Start held in the done cycle is taken one cycle later.
    setPair(768, 784, 0, 16'h0002, 16'h0003);
    fillRandom(800, 816, 3);
    applyStimulus(1, 768, 784);
    watchJob("doneStart", 1, 768, 784, 0, 0, 1'b1, 3, 800, 816);
    @(negedge iClk);
    checkOutput("doneStart_deferBusy", 64'(oBusy), 64'd0);
    checkOutput("doneStart_deferDone", 64'(oDone), 64'd0);
    @(posedge iClk);
    #1 iStart = 1'b0;
    watchJob("deferred", 3, 800, 816, 0, 0, 1'b0, 0, 0, 0);

    // Reset in cycle 3 aborts the run without a done pulse.
    fillRandom(256, 320, 8);
    applyStimulus(8, 256, 320);
    repeat (3) @(negedge iClk);
    iRst = 1'b1;
    #1 checkAllZero("midReset");
    @(negedge iClk);
    checkOutput("midReset_holdDone", 64'(oDone), 64'd0);
    iRst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      checkOutput("abort_busy", 64'(oBusy), 64'd0);
      checkOutput("abort_done", 64'(oDone), 64'd0);
    end
    fillRandom(384, 448, 2);
    applyStimulus(2, 384, 448);
    watchJob("restart", 2, 384, 448, 0, 0, 1'b0, 0, 0, 0);

    // Random jobs.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 24);
      bx  = $urandom_range(0, DEPTH - 1);
      bw  = $urandom_range(0, DEPTH - 1);
      fillRandom(bx, bw, len);
      applyStimulus(len, bx, bw);
      watchJob("random", len, bx, bw, 0, 0, 1'b0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
